// File: rtl/vx_dispatch_lane_batcher_pkg.sv
// Shared definitions for lane-serializing dispatch units: batch counts, pid width
// and the per-batch framing info that travels with each emitted slice.
package vx_dispatch_lane_batcher_pkg;

  localparam int NUM_THREADS_DFLT = 4;
  localparam int NUM_LANES_DFLT   = 2;
  localparam int PID_MAX_W        = 8;

  function automatic int pid_width(input int num_batches);
    return (num_batches > 1) ? $clog2(num_batches) : 1;
  endfunction

  localparam int NUM_BATCHES = NUM_THREADS_DFLT / NUM_LANES_DFLT;
  localparam int PID_W       = pid_width(NUM_BATCHES);

  // pid is held at a fixed maximum width so the struct is usable for any lane split
  typedef struct packed {
    logic [PID_MAX_W-1:0] pid;
    logic                 sop;
    logic                 eop;
  } batch_info_t;

endpackage

// File: rtl/vx_dispatch_lane_batcher_select.sv
// Combinational batch picker: finds the first active batch of a thread mask and the
// next active batch strictly above a given index.
module vx_batch_select
  import vx_dispatch_lane_batcher_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  localparam int NB         = NUM_THREADS / NUM_LANES,
  localparam int PW         = pid_width(NB)
) (
  input  logic [NUM_THREADS-1:0] tmask,
  input  logic [PW-1:0]          cur,
  output logic [PW-1:0]          first_active,
  output logic [PW-1:0]          nxt,
  output logic                   last
);

  logic [NB-1:0] act;

  always_comb begin
    act = '0;
    for (int b = 0; b < NB; b++) begin
      act[b] = |tmask[b*NUM_LANES +: NUM_LANES];
    end
  end

  // Scan from the top so the lowest qualifying batch wins; an empty mask yields batch 0.
  always_comb begin
    first_active = '0;
    nxt          = '0;
    last         = 1'b1;
    for (int b = NB - 1; b >= 0; b--) begin
      if (act[b]) begin
        first_active = PW'(b);
      end
      if (act[b] && (PW'(b) > cur)) begin
        nxt  = PW'(b);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vx_dispatch_lane_batcher.sv
// Serializes a full-warp dispatch packet into NUM_LANES-wide batches, skipping
// batches with no active thread, and tags each batch with pid/sop/eop.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   started=0 | idle or at the first active batch of the presented packet
//   started=1 | part of the packet emitted; bidx_r is the next batch to send
module vx_dispatch_lane_batcher
  import vx_dispatch_lane_batcher_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int META_W      = 128,
  parameter int NT_WIDTH    = 2,
  localparam int NB         = NUM_THREADS / NUM_LANES,
  localparam int PW         = pid_width(NB),
  localparam int SW         = NUM_LANES * XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_THREADS-1:0]   in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  input  logic [META_W-1:0]        in_meta,
  input  logic [NT_WIDTH-1:0]      in_tid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_LANES-1:0]     out_tmask,
  output logic [SW-1:0]            out_rs1_data,
  output logic [SW-1:0]            out_rs2_data,
  output logic [SW-1:0]            out_rs3_data,
  output logic [META_W-1:0]        out_meta,
  output logic [NT_WIDTH-1:0]      out_tid,
  output logic [PW-1:0]            out_pid,
  output logic                     out_sop,
  output logic                     out_eop
);

  logic           started_r;
  logic [PW-1:0]  bidx_r;
  logic [PW-1:0]  first_active;
  logic [PW-1:0]  nxt;
  logic [PW-1:0]  cur;
  logic           last;
  logic           load;

  logic [NUM_LANES-1:0] sl_tmask;
  logic [SW-1:0]        sl_rs1;
  logic [SW-1:0]        sl_rs2;
  logic [SW-1:0]        sl_rs3;
  batch_info_t          info_d;
  batch_info_t          info_r;
  logic                 unused_info;

  assign cur = started_r ? bidx_r : first_active;

  vx_batch_select #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES)
  ) u_sel (
    .tmask        (in_tmask),
    .cur          (cur),
    .first_active (first_active),
    .nxt          (nxt),
    .last         (last)
  );

  assign load     = in_valid && (!out_valid || out_ready);
  assign in_ready = load && last;

  always_comb begin
    sl_tmask = '0;
    sl_rs1   = '0;
    sl_rs2   = '0;
    sl_rs3   = '0;
    for (int b = 0; b < NB; b++) begin
      if (cur == PW'(b)) begin
        sl_tmask = in_tmask[b*NUM_LANES +: NUM_LANES];
        sl_rs1   = in_rs1_data[b*SW +: SW];
        sl_rs2   = in_rs2_data[b*SW +: SW];
        sl_rs3   = in_rs3_data[b*SW +: SW];
      end
    end
    info_d     = '0;
    info_d.pid = PID_MAX_W'(cur);
    info_d.sop = !started_r;
    info_d.eop = last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      started_r    <= 1'b0;
      bidx_r       <= '0;
      out_tmask    <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rs3_data <= '0;
      out_meta     <= '0;
      out_tid      <= '0;
      info_r       <= '0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_tmask    <= sl_tmask;
      out_rs1_data <= sl_rs1;
      out_rs2_data <= sl_rs2;
      out_rs3_data <= sl_rs3;
      out_meta     <= in_meta;
      out_tid      <= in_tid;
      info_r       <= info_d;
      if (last) begin
        started_r <= 1'b0;
      end else begin
        started_r <= 1'b1;
        bidx_r    <= nxt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pid     = info_r.pid[PW-1:0];
  assign out_sop     = info_r.sop;
  assign out_eop     = info_r.eop;
  assign unused_info = ^info_r.pid;

  // Upstream must not change a packet that is partially serialized.
  assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready && started_r) |=>
      ($stable(in_tmask) && $stable(in_rs1_data) && $stable(in_rs2_data) &&
       $stable(in_rs3_data) && $stable(in_meta) && $stable(in_tid)))
    else $error("dispatch packet changed while partially emitted");

  always @(posedge clk) begin
    if (!reset && load) begin
      assert (in_tmask != '0) else $warning("dispatch packet with empty thread mask");
    end
  end

endmodule

// File: tb/tb_vx_dispatch_lane_batcher.sv
// Directed bench for vx_dispatch_lane_batcher with NUM_THREADS=4, NUM_LANES=2, XLEN=32.
module tb_vx_dispatch_lane_batcher;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_tmask;
  logic [127:0]  in_rs1_data;
  logic [127:0]  in_rs2_data;
  logic [127:0]  in_rs3_data;
  logic [127:0]  in_meta;
  logic [1:0]    in_tid;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_tmask;
  logic [63:0]   out_rs1_data;
  logic [63:0]   out_rs2_data;
  logic [63:0]   out_rs3_data;
  logic [127:0]  out_meta;
  logic [1:0]    out_tid;
  logic [0:0]    out_pid;
  logic          out_sop;
  logic          out_eop;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0]  RS1_B0 = 64'h00000002_00000001;
  localparam logic [63:0]  RS1_B1 = 64'h00000004_00000003;
  localparam logic [63:0]  RS2_B1 = 64'h00000104_00000103;
  localparam logic [63:0]  RS3_B0 = 64'h00000202_00000201;
  localparam logic [127:0] META   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  vx_dispatch_lane_batcher #(
    .NUM_THREADS (4),
    .NUM_LANES   (2),
    .XLEN        (32),
    .META_W      (128),
    .NT_WIDTH    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tmask     (in_tmask),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_rs3_data  (in_rs3_data),
    .in_meta      (in_meta),
    .in_tid       (in_tid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tmask    (out_tmask),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rs3_data (out_rs3_data),
    .out_meta     (out_meta),
    .out_tid      (out_tid),
    .out_pid      (out_pid),
    .out_sop      (out_sop),
    .out_eop      (out_eop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    checks++;
    if (out_pid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_rs1_data !== 64'h0 ||
        out_tmask !== 2'b00 || out_meta !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: pid=%b sop=%b eop=%b rs1=%h tmask=%b required all zero",
               out_pid, out_sop, out_eop, out_rs1_data, out_tmask);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_mask();
    in_tmask = 4'b1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready1: in_ready=%b required 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b0 || out_tmask !== 2'b11 || out_rs1_data !== RS1_B0 ||
        out_sop !== 1'b1 || out_eop !== 1'b0) begin
      errors++;
      $display("FAIL full_beat1: v=%b pid=%b tm=%b rs1=%h sop=%b eop=%b required 1 0 11 %h 1 0",
               out_valid, out_pid, out_tmask, out_rs1_data, out_sop, out_eop, RS1_B0);
    end
    checks++;
    if (out_rs3_data !== RS3_B0 || out_meta !== META || out_tid !== 2'd3) begin
      errors++;
      $display("FAIL full_meta: rs3=%h meta=%h tid=%0d required %h %h 3",
               out_rs3_data, out_meta, out_tid, RS3_B0, META);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready2: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b1 || out_tmask !== 2'b11 || out_rs1_data !== RS1_B1 ||
        out_rs2_data !== RS2_B1 || out_sop !== 1'b0 || out_eop !== 1'b1) begin
      errors++;
      $display("FAIL full_beat2: v=%b pid=%b tm=%b rs1=%h rs2=%h sop=%b eop=%b required 1 1 11 %h %h 0 1",
               out_valid, out_pid, out_tmask, out_rs1_data, out_rs2_data, out_sop, out_eop, RS1_B1, RS2_B1);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_skip_batch0();
    in_tmask = 4'b1100;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skip_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b1 || out_tmask !== 2'b11 || out_rs1_data !== RS1_B1 ||
        out_sop !== 1'b1 || out_eop !== 1'b1) begin
      errors++;
      $display("FAIL skip_beat: v=%b pid=%b tm=%b rs1=%h sop=%b eop=%b required 1 1 11 %h 1 1",
               out_valid, out_pid, out_tmask, out_rs1_data, out_sop, out_eop, RS1_B1);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skip_single: out_valid=%b required 0 (no second beat)", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  masks [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic        pids  [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0]  tms   [3] = '{2'b01, 2'b10, 2'b01};
    logic [63:0] rs1s  [3] = '{RS1_B0, RS1_B0, RS1_B1};
    for (int i = 0; i < 3; i++) begin
      in_tmask = masks[i];
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pid !== pids[i] || out_tmask !== tms[i] || out_rs1_data !== rs1s[i] ||
          out_sop !== 1'b1 || out_eop !== 1'b1) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: v=%b pid=%b tm=%b rs1=%h sop=%b eop=%b required 1 %b %b %h 1 1",
                 i, out_valid, out_pid, out_tmask, out_rs1_data, out_sop, out_eop, pids[i], tms[i], rs1s[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    in_tmask = 4'b1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pid !== 1'b0 || out_sop !== 1'b1 ||
          out_rs1_data !== RS1_B0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b v=%b pid=%b sop=%b rs1=%h required 0 1 0 1 %h",
                 i, in_ready, out_valid, out_pid, out_sop, out_rs1_data, RS1_B0);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b1 || out_sop !== 1'b0 || out_eop !== 1'b1) begin
      errors++;
      $display("FAIL stall_beat2: v=%b pid=%b sop=%b eop=%b required 1 1 0 1",
               out_valid, out_pid, out_sop, out_eop);
    end
    step();
  endtask

  task automatic test_reset_mid_packet();
    in_tmask = 4'b1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_beat1: v=%b pid=%b required 1 0", out_valid, out_pid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: out_valid=%b required 0", out_valid);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready: in_ready=%b required 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b0 || out_sop !== 1'b1 || out_eop !== 1'b0 ||
        out_rs1_data !== RS1_B0) begin
      errors++;
      $display("FAIL rst_mid_reemit: v=%b pid=%b sop=%b eop=%b rs1=%h required 1 0 1 0 %h",
               out_valid, out_pid, out_sop, out_eop, out_rs1_data, RS1_B0);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b1 || out_sop !== 1'b0 || out_eop !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_beat2: v=%b pid=%b sop=%b eop=%b required 1 1 0 1",
               out_valid, out_pid, out_sop, out_eop);
    end
    step();
  endtask

  task automatic test_empty_mask();
    in_tmask = 4'b0000;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pid !== 1'b0 || out_tmask !== 2'b00 || out_sop !== 1'b1 ||
        out_eop !== 1'b1) begin
      errors++;
      $display("FAIL empty_beat: v=%b pid=%b tm=%b sop=%b eop=%b required 1 0 00 1 1",
               out_valid, out_pid, out_tmask, out_sop, out_eop);
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_tmask = 4'b0000;
    in_rs1_data = {32'd4, 32'd3, 32'd2, 32'd1};
    in_rs2_data = {32'h104, 32'h103, 32'h102, 32'h101};
    in_rs3_data = {32'h204, 32'h203, 32'h202, 32'h201};
    in_meta = META;
    in_tid = 2'd3;

    test_reset();
    test_full_mask();
    test_skip_batch0();
    test_back_to_back();
    test_stall();
    test_reset_mid_packet();
    test_empty_mask();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_dispatch_lane_batcher.md
Name: vx_dispatch_lane_batcher

Overview:
- Sits directly downstream of the dispatch stage's per-unit elastic buffer, one instance per issue slot per execution unit.
- Takes a full-warp dispatch packet (NUM_THREADS lanes of rs1/rs2/rs3 plus scalar metadata) and serializes it into NUM_LANES-wide batches for execution units narrower than the warp.
- Batches with no active thread are skipped.
- Each emitted batch carries a batch index (pid) and start/end-of-packet flags, so the unit and commit can reassemble the warp.

Parameters:
- NUM_THREADS, 4, threads per warp; power of 2.
- NUM_LANES, 2, lanes per emitted batch; power of 2, ≤ NUM_THREADS.
- XLEN, 32, operand width per thread.
- META_W, 128, width of the pass-through scalar metadata (uuid, wis, op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd).
- NT_WIDTH, 2, width of a thread id; equals log2(NUM_THREADS), minimum 1.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- in_valid, in, 1, dispatch packet valid.
- in_ready, out, 1, packet consumed; asserted only when the last batch is loaded.
- in_tmask, in, NUM_THREADS, active thread mask.
- in_rs1_data, in, NUM_THREADS*XLEN, rs1 operands; thread t is at bits [t*XLEN +: XLEN].
- in_rs2_data, in, NUM_THREADS*XLEN, rs2 operands.
- in_rs3_data, in, NUM_THREADS*XLEN, rs3 operands.
- in_meta, in, META_W, scalar fields; passed through unchanged.
- in_tid, in, NT_WIDTH, last active thread id of the warp; passed through unchanged.
- out_valid, out, 1, batch valid.
- out_ready, in, 1, execution unit accepts the batch.
- out_tmask, out, NUM_LANES, batch slice of tmask.
- out_rs1_data, out, NUM_LANES*XLEN, batch slice of rs1.
- out_rs2_data, out, NUM_LANES*XLEN, batch slice of rs2.
- out_rs3_data, out, NUM_LANES*XLEN, batch slice of rs3.
- out_meta, out, META_W, copy of in_meta.
- out_tid, out, NT_WIDTH, copy of in_tid.
- out_pid, out, PID_W, batch index; PID_W = max(1, log2(NUM_BATCHES)).
- out_sop, out, 1, first emitted batch of the packet.
- out_eop, out, 1, last emitted batch of the packet.

Behaviour:
- NUM_BATCHES = NUM_THREADS/NUM_LANES.
- Batch b covers threads [b*NUM_LANES, (b+1)*NUM_LANES).
- A batch is active if its tmask slice is nonzero.
- State:
  - started_r, 1 bit.
  - bidx_r, PID_W bits.
  - Output register: all out_* fields plus out_valid.
- Reset values: out_valid=0, started_r=0, bidx_r=0, all out_* data=0. Reset is asynchronous and may assert mid-packet.
- cur = started_r ? bidx_r : first_active(in_tmask).
- nxt = first active batch strictly above cur.
- last = (no nxt exists).
- load = in_valid && (!out_valid || out_ready).
- On load:
  - Output register takes batch cur.
  - out_pid=cur.
  - out_sop=!started_r.
  - out_eop=last.
  - meta and tid are copied.
- On load with !last: bidx_r<=nxt, started_r<=1.
- On load with last: started_r<=0.
- in_ready = load && last, combinational. The upstream holds its packet stable until in_ready.
- Latency and throughput:
  - First batch appears 1 cycle after in_valid.
  - One batch per cycle.
  - No bubble between packets when out_ready=1.
- Output stall: while out_valid && !out_ready, all outputs and state hold.
- tmask all zero (illegal upstream): emit one batch with pid=0, sop=eop=1. Simulation assertion fires.
- NUM_LANES==NUM_THREADS: always a single batch, pid=0, sop=eop=1. This degenerates to a pipeline register.
- Reset mid-packet: the partially emitted packet is discarded. The upstream packet is re-sent from batch first_active after reset.
- Simulation assertion: in_tmask/data/meta stable while in_valid && !in_ready && started_r.

Decomposition:
- Shared package (VX_gpu_pkg): NUM_BATCHES and PID_W localparams, and a batch-info struct {pid, sop, eop}.
- Sub-module vx_batch_select, combinational:
  - Inputs: tmask, cur index.
  - Outputs: first_active, nxt, last.
  - Reused by other lane-serializing units.
- Top module holds the registers and handshake.

Test Plan:
All scenarios use NUM_THREADS=4, NUM_LANES=2, XLEN=32.
1. tmask=1111, rs1={t3..t0}={4,3,2,1}, out_ready=1:
   - Beat 1: pid0, tmask 11, rs1 {2,1}, sop=1, eop=0.
   - Beat 2: pid1, rs1 {4,3}, sop=0, eop=1.
   - in_ready high only in the second load cycle.
2. tmask=1100: single beat pid1, tmask 11, sop=eop=1. in_ready in the first load cycle; batch 0 is never emitted.
3. Three back-to-back packets with tmask 0001, 0010, 0100, out_ready=1: three beats on consecutive cycles, pids 0, 0, 1, all sop=eop=1, no bubbles.
4. tmask=1111 with out_ready=0 for 5 cycles after the first beat: outputs hold pid0 unchanged and in_ready stays 0. Release out_ready → pid1 on the next cycle.
5. Assert reset asynchronously between beat 1 and beat 2: out_valid drops immediately. After release, the held packet re-emits from pid0 with sop=1.
6. tmask=0000: one beat, pid0, sop=eop=1; the assertion is flagged.
